// File: rtl/cdb_queue_if.sv
// rtl/cdb_queue_if.sv - completion packet handshake bundle for cdb_queue.
// Used on both sides: FU->queue (ready = fu_ready) and queue->CDB (ready = cdb_ack).
interface cdb_queue_if #(
  parameter int PR_W  = 6,
  parameter int ROB_W = 5,
  parameter int XLEN  = 32
) ();
  logic             valid;
  logic             ready;
  logic [PR_W-1:0]  pr_idx;
  logic [ROB_W-1:0] rob_idx;
  logic [XLEN-1:0]  value;
  logic             br_taken;

  modport master (output valid, pr_idx, rob_idx, value, br_taken, input ready);
  modport slave  (input valid, pr_idx, rob_idx, value, br_taken, output ready);
endinterface

// File: rtl/cdb_queue.sv
// rtl/cdb_queue.sv - in-order completion FIFO between FU writeback and the CDB.
// Optional same-cycle empty-queue bypass from fu to cdb when CDB_BYPASS_EN is defined.
module cdb_queue #(
  parameter int DEPTH = 4,
  parameter int PR_W  = 6,
  parameter int ROB_W = 5,
  parameter int XLEN  = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  cdb_queue_if.slave       fu,
  cdb_queue_if.master      cdb,
  input  logic             squash,
  output logic [CNT_W-1:0] count,
  output logic             almost_full,
  output logic             overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = PR_W + ROB_W + XLEN + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - 1);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] occ;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             byp_take;
  logic [ENT_W-1:0] fu_ent;
  logic [ENT_W-1:0] head_ent;
  logic [ENT_W-1:0] out_ent;

  assign full        = (occ == FULL_CNT);
  assign empty       = (occ == '0);
  assign fu_ent      = {fu.pr_idx, fu.rob_idx, fu.value, fu.br_taken};
  assign head_ent    = mem[head];
  assign fu.ready    = !full;
  assign count       = occ;
  assign almost_full = (occ >= AF_CNT);
  assign pop         = !empty && cdb.ready;

`ifdef CDB_BYPASS_EN
  logic byp;

  // An empty queue forwards the FU packet directly; reset keeps the bus quiet.
  assign byp       = empty && fu.valid && reset;
  assign cdb.valid = !empty || (byp && !squash);
  assign out_ent   = !empty ? head_ent : (byp ? fu_ent : '0);
  assign byp_take  = byp && cdb.ready;
`else
  assign cdb.valid = !empty;
  assign out_ent   = empty ? '0 : head_ent;
  assign byp_take  = 1'b0;
`endif

  assign push = fu.valid && !full && !byp_take;
  assign {cdb.pr_idx, cdb.rob_idx, cdb.value, cdb.br_taken} = out_ent;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      // A drop is a protocol error from the FU regardless of any squash.
      if (fu.valid && full) begin
        overflow <= 1'b1;
      end
      if (squash) begin
        head <= '0;
        tail <= '0;
        occ  <= '0;
      end else begin
        if (push) begin
          tail <= tail + PTR_W'(1);
        end
        if (pop) begin
          head <= head + PTR_W'(1);
        end
        if (push && !pop) begin
          occ <= occ + CNT_W'(1);
        end else if (pop && !push) begin
          occ <= occ - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push && !squash) begin
      mem[tail] <= fu_ent;
    end
  end
endmodule

// File: tb/tb_cdb_queue.sv
// tb/tb_cdb_queue.sv - directed and randomized checks of cdb_queue against a queue model.
`timescale 1ns/1ps
module tb_cdb_queue;
  localparam int DEPTH = 4;
  localparam int PR_W  = 6;
  localparam int ROB_W = 5;
  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [PR_W-1:0]  pr;
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  val;
    logic             br;
  } pkt_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             squash = 1'b0;
  logic [CNT_W-1:0] count;
  logic             almost_full;
  logic             overflow;

  cdb_queue_if #(.PR_W(PR_W), .ROB_W(ROB_W), .XLEN(XLEN)) fu_if ();
  cdb_queue_if #(.PR_W(PR_W), .ROB_W(ROB_W), .XLEN(XLEN)) cdb_if ();

  cdb_queue #(.DEPTH(DEPTH), .PR_W(PR_W), .ROB_W(ROB_W), .XLEN(XLEN)) dut (
    .clock       (clock),
    .reset       (reset),
    .fu          (fu_if.slave),
    .cdb         (cdb_if.master),
    .squash      (squash),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pkt_t fu_pkt();
    return '{pr: fu_if.pr_idx, rob: fu_if.rob_idx, val: fu_if.value, br: fu_if.br_taken};
  endfunction

  function automatic pkt_t cdb_pkt();
    return '{pr: cdb_if.pr_idx, rob: cdb_if.rob_idx, val: cdb_if.value, br: cdb_if.br_taken};
  endfunction

  // Reference model: the queue contents as a plain list plus the sticky error bit.
  pkt_t mq[$];
  bit   m_ovf = 1'b0;

  always @(negedge reset) begin
    mq.delete();
    m_ovf = 1'b0;
  end

  always @(posedge clock) begin
    int  n;
    bit  take;
    if (reset) begin
      n = mq.size();
      if (fu_if.valid && n == DEPTH) m_ovf = 1'b1;
      if (squash) begin
        mq.delete();
      end else begin
        take = BYP && n == 0 && fu_if.valid && cdb_if.ready;
        if (n > 0 && cdb_if.ready) void'(mq.pop_front());
        if (fu_if.valid && n < DEPTH && !take) mq.push_back(fu_pkt());
      end
    end
  end

  always @(negedge clock) begin
    bit   ev;
    pkt_t e;
    if (!reset) begin
      chk("rst_cdb_valid", 64'(cdb_if.valid), 64'd0);
      chk("rst_cdb_data", 64'(cdb_pkt()), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_fu_ready", 64'(fu_if.ready), 64'd1);
      chk("rst_almost_full", 64'(almost_full), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
    end else begin
      ev = (mq.size() > 0) || (BYP && fu_if.valid && !squash);
      e  = (mq.size() > 0) ? mq[0] : fu_pkt();
      chk("cdb_valid", 64'(cdb_if.valid), 64'(ev));
      if (ev) chk("cdb_pkt", 64'(cdb_pkt()), 64'(e));
      chk("count", 64'(count), 64'(mq.size()));
      chk("fu_ready", 64'(fu_if.ready), 64'(mq.size() < DEPTH));
      chk("almost_full", 64'(almost_full), 64'(mq.size() >= DEPTH - 1));
      chk("overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input logic [XLEN-1:0] val, input bit ack, input bit sq);
    fu_if.valid    = v;
    fu_if.pr_idx   = val[PR_W-1:0];
    fu_if.rob_idx  = val[ROB_W+7:8];
    fu_if.value    = val;
    fu_if.br_taken = val[0];
    cdb_if.ready   = ack;
    squash         = sq;
  endtask

  initial begin
    drive(1'b1, 32'h1234, 1'b0, 1'b0);
    repeat (3) tick();
    chk("lit_reset_count", 64'(count), 64'd0);
    chk("lit_reset_valid", 64'(cdb_if.valid), 64'd0);
    chk("lit_reset_ready", 64'(fu_if.ready), 64'd1);

    // First push straight after reset release.
    reset = 1'b1;
    drive(1'b1, 32'h1234, 1'b1, 1'b0);
    fu_if.pr_idx  = 6'd5;
    fu_if.rob_idx = 5'd3;
    if (BYP) begin
      #2;
      chk("lit_byp_first_valid", 64'(cdb_if.valid), 64'd1);
      chk("lit_byp_first_value", 64'(cdb_if.value), 64'h1234);
      chk("lit_byp_first_pr", 64'(cdb_if.pr_idx), 64'd5);
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #2;
      chk("lit_byp_first_count", 64'(count), 64'd0);
    end else begin
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #2;
      chk("lit_first_valid", 64'(cdb_if.valid), 64'd1);
      chk("lit_first_pr", 64'(cdb_if.pr_idx), 64'd5);
      chk("lit_first_rob", 64'(cdb_if.rob_idx), 64'd3);
      chk("lit_first_value", 64'(cdb_if.value), 64'h1234);
      chk("lit_first_count", 64'(count), 64'd1);
      tick();
      chk("lit_first_drained", 64'(count), 64'd0);
    end

    // Fill to full, then overflow, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0);
      tick();
      chk("lit_fill_count", 64'(count), 64'(i));
      if (i == 2) chk("lit_af_at2", 64'(almost_full), 64'd0);
      if (i == 3) chk("lit_af_at3", 64'(almost_full), 64'd1);
    end
    chk("lit_full_ready", 64'(fu_if.ready), 64'd0);
    drive(1'b1, 32'd5, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    #2;
    chk("lit_overflow", 64'(overflow), 64'd1);
    chk("lit_ovf_count", 64'(count), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      #2;
      chk("lit_drain_order", 64'(cdb_if.value), 64'(i));
      tick();
    end
    chk("lit_drain_empty", 64'(count), 64'd0);

    // Back-to-back push and ack.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0);
      #2;
      if (BYP) begin
        chk("lit_stream_byp_value", 64'(cdb_if.value), 64'(i));
        chk("lit_stream_byp_count", 64'(count), 64'd0);
      end else if (i > 0) begin
        chk("lit_stream_value", 64'(cdb_if.value), 64'(i - 1));
        chk("lit_stream_count", 64'(count), 64'd1);
      end
      tick();
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    #2;
    if (!BYP) chk("lit_stream_last", 64'(cdb_if.value), 64'd9);
    tick();
    chk("lit_stream_empty", 64'(count), 64'd0);

    // Squash with a concurrent push.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(8'h10 + i), 1'b0, 1'b0);
      tick();
    end
    chk("lit_presquash_count", 64'(count), 64'd3);
    drive(1'b1, 32'h99, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    #2;
    chk("lit_squash_count", 64'(count), 64'd0);
    chk("lit_squash_valid", 64'(cdb_if.valid), 64'd0);
    chk("lit_squash_ready", 64'(fu_if.ready), 64'd1);
    tick();
    chk("lit_squash_lost", 64'(count), 64'd0);

    // Head held stable under backpressure.
    drive(1'b1, 32'hAB, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("lit_hold_valid", 64'(cdb_if.valid), 64'd1);
      chk("lit_hold_value", 64'(cdb_if.value), 64'hAB);
      tick();
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    chk("lit_hold_drained", 64'(count), 64'd0);

    // Empty-queue latency.
    drive(1'b1, 32'h77, 1'b1, 1'b0);
    #2;
    if (BYP) begin
      chk("lit_77_same_valid", 64'(cdb_if.valid), 64'd1);
      chk("lit_77_same_value", 64'(cdb_if.value), 64'h77);
      tick();
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      #2;
      chk("lit_77_count", 64'(count), 64'd0);
    end else begin
      chk("lit_77_not_yet", 64'(cdb_if.valid), 64'd0);
      tick();
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      #2;
      chk("lit_77_next_value", 64'(cdb_if.value), 64'h77);
      tick();
    end

    // Randomized traffic with occasional squash and asynchronous reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int ack_pct;
      ack_pct = (i < 1500) ? 30 : 80;
      reset = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 99) < 65, $urandom, $urandom_range(0, 99) < ack_pct,
            $urandom_range(0, 19) == 0);
      tick();
    end
    reset = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdb_queue.md
# cdb_queue

Completion buffer between the functional-unit complete output and the common data bus (CDB).
- Accepts at most one completion packet per cycle from the FU stage.
- Holds packets in an in-order FIFO.
- Broadcasts the oldest packet to the ROB/RS/PRF wakeup logic under a valid/ack handshake.
- Absorbs cycles where the CDB consumer cannot take a result, and gives dispatch an early stall signal.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- PR_W, 6, physical register index width
- ROB_W, 5, ROB index width
- XLEN, 32, data width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset: 0 clears the block immediately, 1 releases it
- fu_valid  in  1  FU presents a completion packet
- fu_pr_idx  in  PR_W  destination physical register
- fu_rob_idx  in  ROB_W  ROB entry of the instruction
- fu_value  in  XLEN  result value
- fu_br_taken  in  1  branch-taken flag
- fu_ready  out  1  queue can accept a packet this cycle
- cdb_valid  out  1  head packet valid on CDB
- cdb_pr_idx  out  PR_W  head destination register
- cdb_rob_idx  out  ROB_W  head ROB index
- cdb_value  out  XLEN  head value
- cdb_br_taken  out  1  head branch flag
- cdb_ack  in  1  consumer takes the head this cycle
- squash  in  1  flush all entries (mispredict recovery)
- count  out  $clog2(DEPTH+1)  occupied entries
- almost_full  out  1  count ≥ DEPTH-1; routed to dispatch stall
- overflow  out  1  sticky protocol-error flag

## Operation
- Storage: circular buffer with head and tail pointers of $clog2(DEPTH) bits; both wrap modulo DEPTH.
- count is a separate register; full = (count == DEPTH), empty = (count == 0).
- fu_ready = !full. It is computed from registered state only; a pop in the same cycle does not open a slot.
- Push: fu_valid & fu_ready. Writes the entry at tail, tail+1, count+1.
- Pop: cdb_valid & cdb_ack. Advances head, count-1.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- cdb_valid = !empty. cdb_* fields come straight from the head entry.
- While cdb_valid & !cdb_ack, all cdb_* outputs hold stable.
- cdb_ack with cdb_valid=0 is ignored.
- fu_valid while full: the packet is dropped, state is unchanged, and overflow sets to 1. overflow stays 1 until reset.
- squash has highest priority:
  - head, tail and count go to 0.
  - A push or pop in the same cycle is discarded.
  - overflow is unaffected.
- Entries are not compared with each other; duplicate rob_idx values are forwarded as-is.

## Timing
- Reset values: fu_ready=1, cdb_valid=0, all cdb_* data=0, count=0, almost_full=0, overflow=0. Pointers are 0.
- Reset asserted mid-operation: all stored entries are lost in the same instant (asynchronous). The first push is accepted on the first rising edge after reset returns to 1.
- Latency with bypass not compiled: a push accepted at edge N is visible on cdb_valid after edge N (cycle N+1). This holds even when the queue is empty.
- Throughput: 1 packet per cycle in and 1 per cycle out, sustained with no bubbles.
- almost_full and count are registered-state functions, updated after each edge.
- squash at edge N: cdb_valid=0 and count=0 in cycle N+1.

## Configuration
- CDB_BYPASS_EN defined:
  - When the queue is empty and fu_valid=1, the FU packet drives cdb_* combinationally in the same cycle, with cdb_valid=1.
  - If cdb_ack=1 in that cycle, the packet is not written and count stays 0.
  - If cdb_ack=0, the packet is written normally.
  - squash in that cycle forces cdb_valid=0.
- CDB_BYPASS_EN undefined: no combinational path from fu_* to cdb_*; minimum latency is one cycle.

## Test plan
- Reset held at 0 with fu_valid=1, then released; push pr 5 / rob 3 / value 0x1234 with cdb_ack=1 -> cdb_valid=1, pr 5, rob 3, value 0x1234 the next cycle; count returns to 0 after the ack.
- Four pushes (values 1..4) with cdb_ack=0 -> count=4, fu_ready=0, almost_full=1 from count=3. Then a fifth push -> overflow=1 and the fifth packet is absent. Then ack ×4 -> values 1,2,3,4 in order.
- Continuous push and ack for 10 cycles, values 0..9 -> count constant at 1, pointers wrap, output order 0..9.
- Queue holding 3 entries, then squash together with fu_valid=1 -> next cycle count=0, cdb_valid=0, fu_ready=1; the pushed packet is lost.
- cdb_ack=0 for 3 cycles with head value 0xAB -> cdb_* stable for all 3 cycles.
- CDB_BYPASS_EN: queue empty, fu_valid=1 with value 0x77 and cdb_ack=1 -> cdb_value=0x77 in the same cycle and count stays 0. Without the macro -> 0x77 appears the next cycle.
